// File: rtl/spu_alu_pkg.sv
// Shared types for the two-requester ALU arbiter: opcodes, FSM states and
// datapath sizing.
package spu_alu_pkg;

  localparam int DW             = 128;
  localparam int SHW            = $clog2(DW);
  localparam int MUL_CYCLES_DEF = 3;

  typedef enum logic [3:0] {
    OP_SUB  = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SHL  = 4'b0101,
    OP_SHR  = 4'b0110,
    OP_MUL  = 4'b0111,
    OP_EQ   = 4'b1000,
    OP_PASS = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational 128-bit ALU; the arbiter owns all registers and timing.
module alu_core
  import spu_alu_pkg::*;
(
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          illegal
);

  // Any set bit above the low SHW bits means the shift clears everything.
  logic shift_out;
  assign shift_out = |b[DW-1:SHW];

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      OP_SUB:  result = a - b;
      OP_ADD:  result = a + b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = shift_out ? '0 : a << b[SHW-1:0];
      OP_SHR:  result = shift_out ? '0 : a >> b[SHW-1:0];
      OP_MUL:  result = a * b;
      OP_EQ:   result = {{(DW-1){1'b0}}, (a == b)};
      OP_PASS: result = a;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU; one request in
// flight, multiply takes MUL_CYCLES, everything else one cycle.
module alu_arbiter
  import spu_alu_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [3:0]    req_op0,
  input  logic [3:0]    req_op1,
  input  logic [DW-1:0] req_a0,
  input  logic [DW-1:0] req_b0,
  input  logic [DW-1:0] req_a1,
  input  logic [DW-1:0] req_b1,
  input  logic [3:0]    req_tag0,
  input  logic [3:0]    req_tag1,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_zero,
  output logic          res_err,
  output logic          res_src,
  output logic [3:0]    res_tag
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  state_e        state, state_nx;
  logic [CW-1:0] cnt;
  logic          last;
  logic          gnt;
  logic          accept, finish;
  logic [3:0]    op_q, tag_q;
  logic [DW-1:0] a_q, b_q;
  logic          src_q;
  logic [3:0]    sel_op;
  logic [DW-1:0] alu_res;
  logic          alu_ill;

  // A lone requester always wins; on a tie the one not served last wins.
  assign gnt    = (&req_valid) ? ~last : req_valid[1];
  assign sel_op = gnt ? req_op1 : req_op0;

  always_comb begin
    req_ready = 2'b00;
    if (state == S_IDLE && !reset)
      req_ready[gnt] = req_valid[gnt];
  end

  assign accept    = |req_ready;
  assign finish    = (state == S_EXEC) && (cnt == CW'(1));
  assign res_valid = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept)    state_nx = S_EXEC;
      S_EXEC:  if (finish)    state_nx = S_DONE;
      S_DONE:  if (res_ready) state_nx = S_IDLE;
      default:                state_nx = S_IDLE;
    endcase
  end

  alu_core u_core (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .result  (alu_res),
    .illegal (alu_ill)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      last     <= 1'b1;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      tag_q    <= '0;
      src_q    <= 1'b0;
      res_data <= '0;
      res_zero <= 1'b0;
      res_err  <= 1'b0;
      res_src  <= 1'b0;
      res_tag  <= '0;
    end else if (accept) begin
      op_q  <= sel_op;
      a_q   <= gnt ? req_a1 : req_a0;
      b_q   <= gnt ? req_b1 : req_b0;
      tag_q <= gnt ? req_tag1 : req_tag0;
      src_q <= gnt;
      last  <= gnt;
      cnt   <= (sel_op == OP_MUL) ? CW'(MUL_CYCLES) : CW'(1);
    end else if (state == S_EXEC) begin
      cnt <= cnt - 1'b1;
      if (finish) begin
        res_data <= alu_res;
        res_err  <= alu_ill;
        res_zero <= !alu_ill && (alu_res == '0);
        res_src  <= src_q;
        res_tag  <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized checks of alu_arbiter against a transaction-level
// model of grant order, latency and ALU results.
module tb_alu_arbiter;

  localparam int MULC = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid, req_ready;
  logic [3:0]   req_op0, req_op1, req_tag0, req_tag1;
  logic [127:0] req_a0, req_b0, req_a1, req_b1;
  logic         res_valid, res_ready;
  logic [127:0] res_data;
  logic         res_zero, res_err, res_src;
  logic [3:0]   res_tag;

  int vec = 0;
  int err = 0;
  logic last_srv = 1'b1;

  always #5 clk = ~clk;

  alu_arbiter #(.MUL_CYCLES(MULC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_b0(req_b0),
    .req_a1(req_a1), .req_b1(req_b1), .req_tag0(req_tag0), .req_tag1(req_tag1),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_err(res_err), .res_src(res_src), .res_tag(res_tag)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU: {illegal, result}
  function automatic logic [128:0] ref_alu(input logic [3:0] op, input logic [127:0] a, input logic [127:0] b);
    logic [127:0] r;
    r = '0;
    case (op)
      4'd0:  r = a - b;
      4'd1:  r = a + b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = (b < 128) ? (a << b) : '0;
      4'd6:  r = (b < 128) ? (a >> b) : '0;
      4'd7:  r = a * b;
      4'd8:  r = (a == b) ? 128'd1 : 128'd0;
      4'd15: r = a;
      default: return {1'b1, 128'd0};
    endcase
    return {1'b0, r};
  endfunction

  function automatic logic [127:0] rnd128();
    case ($urandom_range(0, 3))
      0:       return 128'($urandom_range(0, 20));
      1:       return {$urandom, $urandom, $urandom, $urandom};
      2:       return 128'($urandom);
      default: return '0;
    endcase
  endfunction

  // Full transaction: present request(s), check grant, latency, result and hold.
  task automatic txn(input logic [1:0] v,
                     input logic [3:0] o0, input logic [127:0] x0, input logic [127:0] y0, input logic [3:0] t0,
                     input logic [3:0] o1, input logic [127:0] x1, input logic [127:0] y1, input logic [3:0] t1,
                     input int hold);
    logic         g;
    int           n, lat;
    logic [128:0] m;
    logic [127:0] kept;
    logic [3:0]   etag;
    @(negedge clk);
    req_valid = v; req_op0 = o0; req_a0 = x0; req_b0 = y0; req_tag0 = t0;
    req_op1 = o1; req_a1 = x1; req_b1 = y1; req_tag1 = t1;
    g = (v == 2'b11) ? ~last_srv : v[1];
    #1;
    chk("grant", 128'(req_ready), g ? 128'd2 : 128'd1);
    m    = g ? ref_alu(o1, x1, y1) : ref_alu(o0, x0, y0);
    etag = g ? t1 : t0;
    lat  = ((g ? o1 : o0) == 4'b0111) ? MULC : 1;
    last_srv = g;
    @(posedge clk);
    @(negedge clk);
    // Junk on the request side must be ignored while busy.
    req_valid = 2'b11; req_a0 = rnd128(); req_b0 = rnd128(); req_a1 = rnd128(); req_b1 = rnd128();
    req_op0 = 4'($urandom); req_op1 = 4'($urandom);
    n = 0;
    while (!res_valid && n < 20) begin
      @(posedge clk); n++; @(negedge clk);
      if (!res_valid) chk("ready_busy", 128'(req_ready), 128'd0);
    end
    chk("latency", 128'(n), 128'(lat));
    chk("data", res_data, m[127:0]);
    chk("err", 128'(res_err), 128'(m[128]));
    chk("zero", 128'(res_zero), 128'(!m[128] && m[127:0] == 0));
    chk("src", 128'(res_src), 128'(g));
    chk("tag", 128'(res_tag), 128'(etag));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", 128'(res_valid), 128'd1);
      chk("hold_data", res_data, m[127:0]);
      chk("hold_ready", 128'(req_ready), 128'd0);
    end
    res_ready = 1'b1;
    #1;
    chk("hs_ready", 128'(req_ready), 128'd0);
    kept = res_data;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0; req_valid = 2'b00;
    chk("post_valid", 128'(res_valid), 128'd0);
    chk("post_keep", res_data, kept);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd15, 4'd9, 4'd10, 4'd14};
    logic [127:0] ra, rb;
    reset = 1'b1; res_ready = 1'b0;
    req_valid = 2'b11; req_op0 = 0; req_op1 = 0; req_tag0 = 0; req_tag1 = 0;
    req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 128'(req_ready), 128'd0);
    chk("rst_valid", 128'(res_valid), 128'd0);
    chk("rst_data", res_data, 128'd0);
    chk("rst_flags", 128'({res_zero, res_err, res_src, res_tag}), 128'd0);
    reset = 1'b0; req_valid = 2'b00;
    #1;
    chk("idle_ready", 128'(req_ready), 128'd0);

    // Basic subtract from requester 0
    txn(2'b01, 4'b0000, 128'd10, 128'd5, 4'd3, 4'b0000, 128'd0, 128'd0, 4'd0, 0);
    // Tie alternation
    txn(2'b11, 4'b0001, 128'd10, 128'd5, 4'd1, 4'b0010, 128'd10, 128'd5, 4'd2, 0);
    txn(2'b11, 4'b0001, 128'd10, 128'd5, 4'd1, 4'b0010, 128'd10, 128'd5, 4'd2, 0);
    txn(2'b11, 4'b0001, 128'd10, 128'd5, 4'd1, 4'b0010, 128'd10, 128'd5, 4'd2, 0);
    // Multiply latency
    txn(2'b01, 4'b0111, 128'd10, 128'd5, 4'd7, 4'b0000, 128'd0, 128'd0, 4'd0, 0);
    // Equality held under backpressure
    txn(2'b10, 4'b0000, 128'd0, 128'd0, 4'd0, 4'b1000, 128'd10, 128'd10, 4'd9, 4);
    // Illegal opcode
    txn(2'b01, 4'b1010, 128'd10, 128'd5, 4'd5, 4'b0000, 128'd0, 128'd0, 4'd0, 0);
    // Shift boundaries and wraparound
    txn(2'b01, 4'b0101, 128'd1, 128'd127, 4'd4, 4'b0, 128'd0, 128'd0, 4'd0, 0);
    txn(2'b10, 4'b0, 128'd0, 128'd0, 4'd0, 4'b0110, '1, 128'd128, 4'd6, 0);
    txn(2'b01, 4'b0001, '1, 128'd1, 4'd8, 4'b0, 128'd0, 128'd0, 4'd0, 1);

    for (int t = 0; t < 40; t++) begin
      ra = rnd128(); rb = ($urandom_range(0, 4) == 0) ? ra : rnd128();
      txn(2'($urandom_range(1, 3)),
          ops[$urandom_range(0, 12)], ra, rb, 4'($urandom),
          ops[$urandom_range(0, 12)], rnd128(), 128'($urandom_range(0, 200)), 4'($urandom),
          $urandom_range(0, 2));
    end

    // Reset in the middle of a multiply
    @(negedge clk);
    req_valid = 2'b01; req_op0 = 4'b0111; req_a0 = 128'd10; req_b0 = 128'd5; req_tag0 = 4'd11;
    @(posedge clk);
    @(negedge clk); req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk); reset = 1'b1; req_valid = 2'b11;
    #1;
    chk("mid_rst_ready", 128'(req_ready), 128'd0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid", 128'(res_valid), 128'd0);
    chk("mid_rst_ready2", 128'(req_ready), 128'd0);
    chk("mid_rst_data", res_data, 128'd0);
    chk("mid_rst_tag", 128'({res_src, res_tag}), 128'd0);
    reset = 1'b0; req_valid = 2'b00;
    last_srv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      chk("no_ghost", 128'(res_valid), 128'd0);
    end
    txn(2'b11, 4'b0001, 128'd1, 128'd2, 4'd12, 4'b0001, 128'd3, 128'd4, 4'd13, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
